// File: rtl/fp_pkg.sv
// Shared FP register-file types, also imported by the GP/FP move stage and the FP unit.
package fp_pkg;

    localparam int FP_NREGS = 32;
    localparam int FP_AW    = 5;
    localparam int FP_DW    = 32;

    typedef logic [FP_AW-1:0] fp_addr_t;
    typedef logic [FP_DW-1:0] fp_word_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_HELD  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/fp_wb_hold.sv
// One-entry hold buffer for an mtc1 that lost the write port to an FPU write-back.
module fp_wb_hold
    import fp_pkg::*;
#(
    parameter int AW = FP_AW,
    parameter int DW = FP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          wb_busy,
    output logic          hold_valid,
    output logic [AW-1:0] hold_addr,
    output logic [DW-1:0] hold_data,
    output logic          commit
);

    hold_state_e state_q;
    hold_state_e state_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD_EMPTY: if (load)     state_d = HOLD_HELD;
            HOLD_HELD:  if (!wb_busy) state_d = HOLD_EMPTY;
            default:                  state_d = HOLD_EMPTY;
        endcase
    end

    always_comb begin
        hold_valid = (state_q == HOLD_HELD);
        commit     = (state_q == HOLD_HELD) && !wb_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (load && state_q == HOLD_EMPTY) begin
            hold_addr <= load_addr;
            hold_data <= load_data;
        end
    end

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file with a single write port, per-register busy scoreboard and mtc1 hold buffer.
module fp_regfile_sb
    import fp_pkg::*;
#(
    parameter int NREGS = FP_NREGS,
    parameter int AW    = FP_AW,
    parameter int DW    = FP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_busy,
    input  logic          mtc1_valid,
    input  logic [AW-1:0] mtc1_addr,
    input  logic [DW-1:0] mtc1_data,
    output logic          mtc1_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dest,
    output logic          issue_ready,
    input  logic          fpu_wb_valid,
    input  logic [AW-1:0] fpu_wb_addr,
    input  logic [DW-1:0] fpu_wb_data
);

    logic [DW-1:0]    mem [NREGS];
    logic [NREGS-1:0] busy;

    logic          hold_valid;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic          hold_commit;

    logic          mtc1_acc;
    logic          issue_acc;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    assign mtc1_ready  = !hold_valid && !busy[mtc1_addr];
    assign issue_ready = !busy[issue_dest] && !(hold_valid && hold_addr == issue_dest);
    assign mtc1_acc    = mtc1_valid && mtc1_ready;
    assign issue_acc   = issue_valid && issue_ready;

    assign rd_data = mem[rd_addr];
    assign rd_busy = busy[rd_addr] || (hold_valid && hold_addr == rd_addr);

    fp_wb_hold #(
        .AW(AW),
        .DW(DW)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mtc1_acc && fpu_wb_valid),
        .load_addr (mtc1_addr),
        .load_data (mtc1_data),
        .wb_busy   (fpu_wb_valid),
        .hold_valid(hold_valid),
        .hold_addr (hold_addr),
        .hold_data (hold_data),
        .commit    (hold_commit)
    );

    // Write-port arbitration: FPU write-back, then held mtc1, then a direct mtc1.
    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        if (fpu_wb_valid) begin
            we = 1'b1;
            wa = fpu_wb_addr;
            wd = fpu_wb_data;
        end else if (hold_commit) begin
            we = 1'b1;
            wa = hold_addr;
            wd = hold_data;
        end else if (mtc1_acc) begin
            we = 1'b1;
            wa = mtc1_addr;
            wd = mtc1_data;
        end
    end

    // NOTE: the array is reset on purpose (registers must read 0), so it builds from flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // The set follows the clear so a same-address issue keeps ownership of the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (fpu_wb_valid) busy[fpu_wb_addr] <= 1'b0;
            if (issue_acc)    busy[issue_dest]  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed self-checking bench for fp_regfile_sb.
module tb_fp_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_busy;
    logic        mtc1_valid;
    logic [4:0]  mtc1_addr;
    logic [31:0] mtc1_data;
    logic        mtc1_ready;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        fpu_wb_valid;
    logic [4:0]  fpu_wb_addr;
    logic [31:0] fpu_wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_regfile_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .mtc1_valid  (mtc1_valid),
        .mtc1_addr   (mtc1_addr),
        .mtc1_data   (mtc1_data),
        .mtc1_ready  (mtc1_ready),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .fpu_wb_valid(fpu_wb_valid),
        .fpu_wb_addr (fpu_wb_addr),
        .fpu_wb_data (fpu_wb_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mtc1_valid   = 1'b0;
        issue_valid  = 1'b0;
        fpu_wb_valid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        rd_addr = a;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0; mtc1_addr = '0; mtc1_data = '0; issue_dest = '0;
        fpu_wb_addr = '0; fpu_wb_data = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rd_busy", {31'b0, rd_busy}, 32'h0);
        check("reset_mtc1_ready", {31'b0, mtc1_ready}, 32'h1);
        check("reset_issue_ready", {31'b0, issue_ready}, 32'h1);

        // Direct mtc1 to $f3
        mtc1_valid = 1'b1; mtc1_addr = 5'd3; mtc1_data = 32'h3F800000;
        tick();
        idle();
        rd(5'd3);
        check("mtc1_f3_data", rd_data, 32'h3F800000);
        check("mtc1_f3_busy", {31'b0, rd_busy}, 32'h0);

        // Issue to $f7, then RAW/WAW visibility
        issue_valid = 1'b1; issue_dest = 5'd7;
        tick();
        idle();
        mtc1_addr = 5'd7;
        rd(5'd7);
        check("issue7_rd_busy", {31'b0, rd_busy}, 32'h1);
        check("issue7_issue_ready", {31'b0, issue_ready}, 32'h0);
        check("issue7_mtc1_ready", {31'b0, mtc1_ready}, 32'h0);
        mtc1_valid = 1'b1; mtc1_data = 32'hDEADBEEF;
        tick();
        idle();
        check("waw_refused_data", rd_data, 32'h0);
        fpu_wb_valid = 1'b1; fpu_wb_addr = 5'd7; fpu_wb_data = 32'h40490FDB;
        tick();
        idle();
        check("wb7_rd_busy", {31'b0, rd_busy}, 32'h0);
        check("wb7_rd_data", rd_data, 32'h40490FDB);

        // Collision: fpu_wb $f2 and mtc1 $f5
        fpu_wb_valid = 1'b1; fpu_wb_addr = 5'd2; fpu_wb_data = 32'h11111111;
        mtc1_valid = 1'b1; mtc1_addr = 5'd5; mtc1_data = 32'h22222222;
        tick();
        idle();
        issue_dest = 5'd5;
        rd(5'd2);
        check("coll_f2_data", rd_data, 32'h11111111);
        rd(5'd5);
        check("coll_f5_busy", {31'b0, rd_busy}, 32'h1);
        check("coll_f5_data_old", rd_data, 32'h0);
        check("coll_mtc1_ready", {31'b0, mtc1_ready}, 32'h0);
        check("coll_issue_ready_f5", {31'b0, issue_ready}, 32'h0);
        tick();
        check("commit_f5_data", rd_data, 32'h22222222);
        check("commit_f5_busy", {31'b0, rd_busy}, 32'h0);
        check("commit_mtc1_ready", {31'b0, mtc1_ready}, 32'h1);

        // Collision followed by three back-to-back write-backs
        fpu_wb_valid = 1'b1; fpu_wb_addr = 5'd10; fpu_wb_data = 32'hA0A0A0A0;
        mtc1_valid = 1'b1; mtc1_addr = 5'd6; mtc1_data = 32'h66666666;
        tick();
        mtc1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fpu_wb_addr = 5'(11 + k);
            fpu_wb_data = 32'hB0000000 + 32'(k);
            tick();
            rd(5'd6);
            check("held_f6_busy", {31'b0, rd_busy}, 32'h1);
            check("held_f6_data", rd_data, 32'h0);
            check("held_mtc1_ready", {31'b0, mtc1_ready}, 32'h0);
        end
        idle();
        tick();
        check("commit4_f6_data", rd_data, 32'h66666666);
        check("commit4_f6_busy", {31'b0, rd_busy}, 32'h0);
        rd(5'd13);
        check("wb_f13_data", rd_data, 32'hB0000002);
        check("wb_nonbusy_f13_busy", {31'b0, rd_busy}, 32'h0);

        // Same-cycle issue and write-back on $f9: the set wins
        issue_valid = 1'b1; issue_dest = 5'd9;
        fpu_wb_valid = 1'b1; fpu_wb_addr = 5'd9; fpu_wb_data = 32'h99999999;
        tick();
        idle();
        rd(5'd9);
        check("iss_wb9_busy", {31'b0, rd_busy}, 32'h1);
        check("iss_wb9_data", rd_data, 32'h99999999);
        check("iss_wb9_issue_ready", {31'b0, issue_ready}, 32'h0);

        // Reset while HELD with busy[4] set
        issue_valid = 1'b1; issue_dest = 5'd4;
        tick();
        idle();
        fpu_wb_valid = 1'b1; fpu_wb_addr = 5'd9; fpu_wb_data = 32'h12345678;
        mtc1_valid = 1'b1; mtc1_addr = 5'd8; mtc1_data = 32'h88888888;
        tick();
        idle();
        rd(5'd4);
        check("pre_rst_f4_busy", {31'b0, rd_busy}, 32'h1);
        rd(5'd8);
        check("pre_rst_f8_held", {31'b0, rd_busy}, 32'h1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("in_rst_f8_busy", {31'b0, rd_busy}, 32'h0);
        check("in_rst_mtc1_ready", {31'b0, mtc1_ready}, 32'h1);
        @(negedge clk) rst_n = 1'b1;
        issue_dest = 5'd4;
        mtc1_addr = 5'd8;
        #1;
        check("post_rst_issue_ready", {31'b0, issue_ready}, 32'h1);
        check("post_rst_mtc1_ready", {31'b0, mtc1_ready}, 32'h1);
        for (int r = 0; r < 32; r++) begin
            rd(5'(r));
            check("post_rst_data", rd_data, 32'h0);
            check("post_rst_busy", {31'b0, rd_busy}, 32'h0);
        end
        tick();
        rd(5'd8);
        check("post_rst_no_commit", rd_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_regfile_sb.md
# fp_regfile_sb

Floating-point register file with a write-back scoreboard. It sits directly upstream of the GP/FP move stage and supplies its FP operand (the mfc1 source). It also takes that stage's mtc1 result and the write-backs from the multi-cycle FP unit. Write-port conflicts are arbitrated through a one-entry hold buffer, and a per-register busy flag is tracked so that decode can stall on RAW/WAW hazards.

## Interface
Parameters:
- NREGS, 32, number of FP registers
- AW, 5, register address width (log2 NREGS)
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  AW  read address for the mfc1 / FP operand
- rd_data  out  DW  combinational read of the committed array
- rd_busy  out  1  the addressed register has a pending write (busy flag set, or held in the hold buffer)
- mtc1_valid  in  1  mtc1 write request
- mtc1_addr  in  AW  mtc1 destination
- mtc1_data  in  DW  value produced by the GP to FP move
- mtc1_ready  out  1  mtc1 is accepted this cycle
- issue_valid  in  1  an FP-unit op is issuing and claims a destination
- issue_dest  in  AW  destination of the issuing op
- issue_ready  out  1  the issue is accepted this cycle
- fpu_wb_valid  in  1  FP unit result write-back; always accepted
- fpu_wb_addr  in  AW  write-back destination
- fpu_wb_data  in  DW  write-back value

## Operation
- Storage: array of NREGS x DW, a busy vector of NREGS bits, and a hold buffer (hold_valid, hold_addr, hold_data).
- Single write port, with priority fpu_wb > hold buffer > direct mtc1.
- mtc1_ready = !hold_valid && !busy[mtc1_addr]. A WAW against an in-flight FPU op is refused.
- Accepted mtc1 handling:
  - With no fpu_wb in the same cycle, it writes the array directly.
  - With an fpu_wb in the same cycle, it is captured into the hold buffer.
- Hold-buffer FSM:
  - EMPTY -> HELD on an mtc1/fpu_wb collision.
  - HELD -> EMPTY on the first cycle with fpu_wb_valid=0; the held value is written in that cycle.
  - HELD with another fpu_wb present: it stays HELD and retries.
- issue_ready = !busy[issue_dest] && !(hold_valid && hold_addr==issue_dest).
- An accepted issue sets busy[issue_dest].
- fpu_wb writes the array and clears busy[fpu_wb_addr].
- Same address, same cycle, issue + wb: the set wins and busy ends at 1, because the new op owns the register.
- fpu_wb to a non-busy register is a protocol violation. The data is still written, busy stays 0, and no error is signalled.
- rd_busy = busy[rd_addr] || (hold_valid && hold_addr==rd_addr).
- No read bypass. A consumer must wait for rd_busy=0, and sees the new value the cycle after the write edge.

## Timing
- Reset (asynchronous assert, synchronous release): all array entries 0, busy all 0, hold_valid 0.
  - Outputs after reset: rd_data=0, rd_busy=0, mtc1_ready=1, issue_ready=1.
- Reset mid-operation discards the held mtc1 and all busy flags immediately.
- Write latency: 1 cycle. A write accepted at edge N is visible on rd_data after edge N.
- A held mtc1 commits at the first edge where fpu_wb_valid=0, giving a 2-cycle minimum latency.
- Ready outputs are combinational from current state only. They never depend on same-cycle valids.
- mtc1_ready stays low for the whole time the hold buffer is full. There is at most one held entry.

## Structure
- Shared package fp_pkg: FP_NREGS=32, FP_AW=5, FP_DW=32, typedef fp_addr_t, typedef fp_word_t. The move stage and the FP unit import the same package.
- Sub-module fp_wb_hold: the hold buffer and its EMPTY/HELD FSM. It outputs hold_valid/addr/data and a commit strobe.
- Array, scoreboard and ready logic stay in the top module.
- Expected size: about 200 lines of RTL.

## Test plan
- Reset, then mtc1 $f3=0x3F800000, then rd_addr=3 -> rd_data=0x3F800000 the next cycle, rd_busy=0.
- issue_dest=7, then rd_addr=7 -> rd_busy=1, issue_ready=0 for dest 7 and mtc1_ready=0 for addr 7. fpu_wb $f7=0x40490FDB -> rd_busy=0 next cycle, rd_data=0x40490FDB.
- Same cycle: fpu_wb $f2=0x11111111 and mtc1 $f5=0x22222222 -> $f2 written first and $f5 held (rd_busy[5]=1, mtc1_ready=0). Next idle cycle: $f5 reads 0x22222222 and mtc1_ready=1.
- Collision followed by 3 back-to-back fpu_wb -> hold stays HELD for 3 cycles and commits in the 4th.
- issue_dest=9 and fpu_wb $f9 in the same cycle -> busy[9]=1 afterwards.
- rst_n pulsed low while HELD with busy[4]=1 -> rd_busy=0 everywhere, both readies=1, and all registers read 0.
